// File: rtl/sram_arb_pkg.sv
// Shared constants and FSM state type for the SRAM arbiter.
// Geometry matches the 2048x39 single-port SRAM wrapper.
package sram_arb_pkg;

  localparam int SRAM_ADR_W  = 11;
  localparam int SRAM_DATA_W = 39;
  localparam int SRAM_DEPTH  = 2048;

  typedef enum logic [0:0] {
    ARB_INIT,
    ARB_RUN
  } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant from req and a rotating pointer.
// The pointer moves past the winner after every grant.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_en,
  input  logic [N-1:0]         i_req,
  output logic [N-1:0]         o_gnt,
  output logic [$clog2(N)-1:0] o_idx,
  output logic                 o_any
);

  localparam int PW = $clog2(N);

  logic [PW-1:0] r_ptr;
  logic [PW-1:0] w_nxt;
  logic [PW-1:0] w_j;

  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    w_j   = '0;
    for (int i = 0; i < N; i++) begin
      w_j = PW'((int'(r_ptr) + i) % N);
      if (i_en && !o_any && i_req[w_j]) begin
        o_any      = 1'b1;
        o_gnt[w_j] = 1'b1;
        o_idx      = w_j;
      end
    end
  end

  assign w_nxt = (o_idx == PW'(N - 1)) ? '0
                                       : o_idx + PW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (o_any) begin
      r_ptr <= w_nxt;
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// Round-robin share of one single-port SRAM among N_REQ requesters.
// Define SRAM_ARB_INIT_EN to zero-fill the whole SRAM after reset.
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int N_REQ  = 4,
  parameter int ADR_W  = SRAM_ADR_W,
  parameter int DATA_W = SRAM_DATA_W
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [N_REQ-1:0]        req_valid,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [N_REQ-1:0]        req_we,
  input  logic [N_REQ*ADR_W-1:0]  req_adr,
  input  logic [N_REQ*DATA_W-1:0] req_d,
  output logic [N_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]       rsp_q,
  output logic [ADR_W-1:0]        sram_adr,
  output logic [DATA_W-1:0]       sram_d,
  output logic                    sram_we,
  input  logic [DATA_W-1:0]       sram_q,
  output logic                    busy_init
);

  localparam int IW = $clog2(N_REQ);

  logic             w_run;
  logic             w_en;
  logic             w_any;
  logic             w_rsp;
  logic [N_REQ-1:0] w_gnt;
  logic [IW-1:0]    w_idx;
  logic [ADR_W-1:0] r_adr;
  logic             r_rd;
  logic [IW-1:0]    r_ridx;

`ifdef SRAM_ARB_INIT_EN
  arb_state_t       r_state;
  logic [ADR_W-1:0] r_cnt;

  // Counter wraps to 0 on the last address and then sits idle.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= ARB_INIT;
      r_cnt   <= '0;
    end else if (r_state == ARB_INIT) begin
      r_cnt <= r_cnt + ADR_W'(1);
      if (r_cnt == ADR_W'(SRAM_DEPTH - 1)) begin
        r_state <= ARB_RUN;
      end
    end
  end

  assign w_run     = (r_state == ARB_RUN);
  assign busy_init = ~w_run;
`else
  assign w_run     = 1'b1;
  assign busy_init = 1'b0;
`endif

  assign w_en = w_run & ~RST;

  rr_arbiter #(
    .N (N_REQ)
  ) u_rr (
    .clk   (CLK),
    .rst   (RST),
    .i_en  (w_en),
    .i_req (req_valid),
    .o_gnt (w_gnt),
    .o_idx (w_idx),
    .o_any (w_any)
  );

  assign req_ready = w_gnt;

  always_comb begin
    sram_we  = 1'b0;
    sram_adr = r_adr;
    sram_d   = '0;
`ifdef SRAM_ARB_INIT_EN
    if (!w_run && !RST) begin
      sram_we  = 1'b1;
      sram_adr = r_cnt;
    end
`endif
    if (w_any) begin
      sram_we  = req_we[w_idx];
      sram_adr = req_adr[w_idx*ADR_W +: ADR_W];
      sram_d   = req_d[w_idx*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_adr  <= '0;
      r_rd   <= 1'b0;
      r_ridx <= '0;
    end else begin
      r_adr  <= sram_adr;
      r_rd   <= w_any & ~req_we[w_idx];
      r_ridx <= w_idx;
    end
  end

  // A reset in the response cycle drops the pending read data.
  assign w_rsp = r_rd & ~RST;

  always_comb begin
    rsp_valid = '0;
    if (w_rsp) begin
      rsp_valid[r_ridx] = 1'b1;
    end
  end

  assign rsp_q = w_rsp ? sram_q : '0;

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Shares the single-port 2048x39 SRAM wrapper between N requesters using round-robin arbitration.
- Each requester uses a valid/ready handshake. Read data comes back on a shared bus, with a per-requester response strobe.
- Sits between the lookup/update engines and the SRAM instance, and drives its ADR/D/WE pins directly.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- ADR_W, 11, SRAM address width.
- DATA_W, 39, SRAM word width.

Ports:
- CLK  input  1  clock, shared with the SRAM.
- RST  input  1  synchronous reset, active-high.
- req_valid  input  N_REQ  request pending, one bit per requester.
- req_ready  output  N_REQ  request accepted this cycle (grant), one-hot or zero.
- req_we  input  N_REQ  1 = write, 0 = read.
- req_adr  input  N_REQ*ADR_W  packed addresses; requester i at [i*ADR_W +: ADR_W].
- req_d  input  N_REQ*DATA_W  packed write data.
- rsp_valid  output  N_REQ  read data valid for requester i.
- rsp_q  output  DATA_W  read data, shared by all requesters.
- sram_adr  output  ADR_W  to SRAM ADR.
- sram_d  output  DATA_W  to SRAM D.
- sram_we  output  1  to SRAM WE.
- sram_q  input  DATA_W  from SRAM Q.
- busy_init  output  1  high while initialisation is running (tied 0 without the feature).

Behaviour:
- Reset values:
  - req_ready=0, rsp_valid=0, rsp_q=0, sram_we=0, sram_adr=0, sram_d=0.
  - Round-robin pointer=0 (requester 0 has highest priority first).
- States:
  - RUN: arbitration active.
  - INIT: present only with the optional feature.
  - RST forces the reset state from any state, mid-operation included. Any in-flight read response is dropped; rsp_valid is 0 the next cycle.
- Arbitration (RUN):
  - The grant is combinational from req_valid and the pointer. The first valid requester at or after the pointer wins.
  - req_ready[g]=1 for the winner only; the transfer happens when valid and ready are both high.
  - The pointer advances to g+1, modulo N_REQ, after a grant.
  - With no requests the pointer holds and req_ready=0.
- SRAM drive:
  - sram_adr, sram_d and sram_we are the winner's fields, unregistered, in the grant cycle.
  - With no grant: sram_we=0 and sram_adr holds its previous value.
- Read latency:
  - The SRAM returns Q one cycle after the address is sampled.
  - rsp_valid[g] pulses exactly one cycle after a read grant to g, with rsp_q=sram_q in that cycle.
  - Writes produce no response.
- Throughput: one access per cycle. Back-to-back reads from different requesters give back-to-back rsp_valid pulses, in grant order.
- Read-after-write to the same address in consecutive cycles returns the new data (SRAM write-then-read ordering). The arbiter adds no forwarding.
- req_* inputs must be held stable while req_valid is high and req_ready is low. Dropping valid before grant is allowed.
- rsp_valid is one-hot or zero.

Optional Feature:
- Macro: SRAM_ARB_INIT_EN.
- Defined:
  - After RST the FSM enters INIT and writes 0 to addresses 0..2047, one per cycle (sram_we=1, sram_d=0, sram_adr=counter).
  - busy_init=1 and req_ready=0 throughout INIT.
  - After address 2047 is written, the FSM moves to RUN on the next cycle. INIT lasts exactly 2048 cycles.
  - The counter wraps to 0 and stops.
- Undefined: no INIT state, reset goes straight to RUN, and busy_init is tied 0.

Decomposition:
- Package sram_arb_pkg:
  - constants SRAM_ADR_W=11, SRAM_DATA_W=39, SRAM_DEPTH=2048;
  - state enum arb_state_t {ARB_INIT, ARB_RUN}.
- Sub-module rr_arbiter (N parameter): takes req and pointer, produces a one-hot grant and the next pointer. It is purely combinational plus the pointer register.
- The top level holds the FSM, the init counter, the response pipeline register (read flag plus grant index) and the SRAM muxing.

Test Plan:
- Reset, then requester 1 writes 0x12345 at address 0x005, then requester 2 reads 0x005. Requester 2 gets rsp_valid[2] one cycle after its grant with rsp_q=0x12345; rsp_valid is 0 for the write.
- All 4 requesters hold reads for 8 cycles. Grants go 0,1,2,3,0,1,2,3 with one rsp_valid per cycle, each matching its grant one cycle later.
- Only requester 3 active with the pointer at 0. Requester 3 is granted immediately, then the pointer is 0. Idle cycles give req_ready=0 and sram_we=0.
- Assert RST in the cycle after a read grant. rsp_valid stays 0, the pointer returns to 0 and all outputs go to their reset values.
- With SRAM_ARB_INIT_EN, request from requester 0 during INIT. req_ready stays 0 for 2048 cycles with busy_init=1; the grant comes in the first RUN cycle; a read of address 0x7FF returns 0.
- Write address 0x7FF, then read address 0x7FF in the next cycle from another requester. The new data is returned, confirming the full 11-bit address range.
